// File: rtl/ball_physics_if.sv
// Bundles the character inputs and ball/score outputs of the ball physics engine.
// slave is the engine side; master is the side driving characters and reading the ball.
interface ball_physics_if;
  logic [9:0] Char1X;
  logic [9:0] Char1Y;
  logic [9:0] Char2X;
  logic [9:0] Char2Y;
  logic [9:0] CharS;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic       Goal1;
  logic       Goal2;
  logic [3:0] Score1;
  logic [3:0] Score2;
  logic [1:0] GameState;

  modport master (
    output Char1X, Char1Y, Char2X, Char2Y, CharS,
    input  BallX, BallY, BallS, Goal1, Goal2, Score1, Score2, GameState
  );

  modport slave (
    input  Char1X, Char1Y, Char2X, Char2Y, CharS,
    output BallX, BallY, BallS, Goal1, Goal2, Score1, Score2, GameState
  );
endinterface

// File: rtl/ball_physics.sv
// Per-frame ball kinematics for head-soccer: serve/play/goal sequencing, player contact,
// wall/ceiling/floor handling, goal detection and score keeping.
module ball_physics #(
  parameter int BALL_X_START = 320,
  parameter int BALL_Y_START = 200,
  parameter int BALL_SIZE    = 16,
  parameter int X_MAX        = 639,
  parameter int FLOOR_Y      = 400,
  parameter int GOAL_TOP     = 320,
  parameter int GRAVITY      = 1,
  parameter int MAX_VY       = 15,
  parameter int KICK_VX      = 6,
  parameter int KICK_VY      = -10,
  parameter int SERVE_FRAMES = 30,
  parameter int PAUSE_FRAMES = 60
) (
  input logic           frame_clk,
  input logic           Reset,
  ball_physics_if.slave bus
);

  typedef enum logic [1:0] {StServe = 2'd0, StPlay = 2'd1, StGoal = 2'd2} state_e;

  localparam logic [9:0]         XStart    = 10'(BALL_X_START);
  localparam logic [9:0]         YStart    = 10'(BALL_Y_START);
  localparam logic [9:0]         XRight    = 10'(X_MAX - BALL_SIZE);
  localparam logic [9:0]         YRest     = 10'(FLOOR_Y - BALL_SIZE);
  localparam logic [9:0]         GoalTop   = 10'(GOAL_TOP);
  localparam logic signed [10:0] XRightS   = 11'(X_MAX - BALL_SIZE);
  localparam logic signed [10:0] YRestS    = 11'(FLOOR_Y - BALL_SIZE);
  localparam logic signed [10:0] Gravity   = 11'(GRAVITY);
  localparam logic signed [10:0] MaxVy     = 11'(MAX_VY);
  localparam logic signed [10:0] KickVx    = 11'(KICK_VX);
  localparam logic signed [10:0] KickVy    = 11'(KICK_VY);
  localparam logic signed [10:0] OneS      = 11'sd1;
  localparam logic signed [10:0] TwoS      = 11'sd2;
  localparam logic [11:0]        Size12    = 12'(BALL_SIZE);
  localparam logic [11:0]        Half12    = 12'(BALL_SIZE / 2);
  localparam logic [7:0]         ServeLast = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         PauseLast = 8'(PAUSE_FRAMES - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [9:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic signed [10:0] vx_q, vx_d, vy_q, vy_d;
  logic [3:0]        score1_q, score1_d, score2_q, score2_d;
  logic              goal1_q, goal1_d, goal2_q, goal2_d;

  logic signed [10:0] vx_n, vy_n, nx, ny;
  logic [11:0] bx, by, c1x, c1y, c2x, c2y, cs, cs_half;
  logic        hit1, hit2, right1, right2;

  // Overlap math is widened to 12 bits so CX+CharS never wraps.
  assign bx      = {2'b00, ball_x_q};
  assign by      = {2'b00, ball_y_q};
  assign c1x     = {2'b00, bus.Char1X};
  assign c1y     = {2'b00, bus.Char1Y};
  assign c2x     = {2'b00, bus.Char2X};
  assign c2y     = {2'b00, bus.Char2Y};
  assign cs      = {2'b00, bus.CharS};
  assign cs_half = {3'b000, bus.CharS[9:1]};

  assign hit1 = (bx < c1x + cs) && (bx + Size12 > c1x) && (by < c1y + cs) && (by + Size12 > c1y);
  assign hit2 = (bx < c2x + cs) && (bx + Size12 > c2x) && (by < c2y + cs) && (by + Size12 > c2y);
  assign right1 = (bx + Half12) >= (c1x + cs_half);
  assign right2 = (bx + Half12) >= (c2x + cs_half);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    score1_d = score1_q;
    score2_d = score2_q;
    goal1_d  = 1'b0;
    goal2_d  = 1'b0;
    vx_n     = vx_q;
    vy_n     = vy_q;
    nx       = '0;
    ny       = '0;

    unique case (state_q)
      StServe: begin
        ball_x_d = XStart;
        ball_y_d = YStart;
        vx_d     = '0;
        vy_d     = '0;
        if (cnt_q == ServeLast) begin
          cnt_d   = '0;
          state_d = StPlay;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StPlay: begin
        vy_n = vy_q + Gravity;
        if (vy_n > MaxVy) vy_n = MaxVy;
        if (hit1) begin
          vx_n = right1 ? KickVx : -KickVx;
          vy_n = KickVy;
        end else if (hit2) begin
          vx_n = right2 ? KickVx : -KickVx;
          vy_n = KickVy;
        end

        nx = $signed({1'b0, ball_x_q}) + vx_n;
        ny = $signed({1'b0, ball_y_q}) + vy_n;

        // Goal test uses the current Y, before this frame's vertical move.
        if (nx[10]) begin
          ball_x_d = '0;
          if (ball_y_q >= GoalTop) begin
            goal2_d  = 1'b1;
            score2_d = (score2_q == 4'hf) ? score2_q : score2_q + 4'd1;
            state_d  = StGoal;
            cnt_d    = '0;
          end else begin
            vx_n = -vx_n;
          end
        end else if (nx > XRightS) begin
          ball_x_d = XRight;
          if (ball_y_q >= GoalTop) begin
            goal1_d  = 1'b1;
            score1_d = (score1_q == 4'hf) ? score1_q : score1_q + 4'd1;
            state_d  = StGoal;
            cnt_d    = '0;
          end else begin
            vx_n = -vx_n;
          end
        end else begin
          ball_x_d = nx[9:0];
        end

        if (ny[10]) begin
          ball_y_d = '0;
          vy_n     = -vy_n;
        end else if (ny > YRestS) begin
          ball_y_d = YRest;
          vy_n     = -(vy_n >>> 1);
          if ((vy_n > -TwoS) && (vy_n < TwoS)) vy_n = '0;
          if (vx_n[10]) vx_n = vx_n + OneS;
          else if (vx_n != '0) vx_n = vx_n - OneS;
        end else begin
          ball_y_d = ny[9:0];
        end

        vx_d = vx_n;
        vy_d = vy_n;
      end

      StGoal: begin
        if (cnt_q == PauseLast) begin
          ball_x_d = XStart;
          ball_y_d = YStart;
          vx_d     = '0;
          vy_d     = '0;
          cnt_d    = '0;
          state_d  = StServe;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = StServe;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= StServe;
      cnt_q    <= '0;
      ball_x_q <= XStart;
      ball_y_q <= YStart;
      vx_q     <= '0;
      vy_q     <= '0;
      score1_q <= '0;
      score2_q <= '0;
      goal1_q  <= 1'b0;
      goal2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      goal1_q  <= goal1_d;
      goal2_q  <= goal2_d;
    end
  end

  assign bus.BallX     = ball_x_q;
  assign bus.BallY     = ball_y_q;
  assign bus.BallS     = 10'(BALL_SIZE);
  assign bus.Goal1     = goal1_q;
  assign bus.Goal2     = goal2_q;
  assign bus.Score1    = score1_q;
  assign bus.Score2    = score2_q;
  assign bus.GameState = state_q;

endmodule

// File: tb/tb_ball_physics.sv
// Self-checking bench for ball_physics: directed sequences plus a randomized run, all compared
// frame by frame against an integer reference model of the game rules.
module tb_ball_physics;

  logic frame_clk = 1'b0;
  logic rst = 1'b1;
  int c1x = 0, c1y = 368, c2x = 600, c2y = 368, cs = 32;
  int n_tests = 0, n_fail = 0;

  // Reference model state: plain integers, state 0/1/2 = serve/play/goal.
  int m_x, m_y, m_vx, m_vy, m_st, m_cnt, m_s1, m_s2, m_g1, m_g2;

  ball_physics_if bus ();

  assign bus.Char1X = 10'(c1x);
  assign bus.Char1Y = 10'(c1y);
  assign bus.Char2X = 10'(c2x);
  assign bus.Char2Y = 10'(c2y);
  assign bus.CharS  = 10'(cs);

  ball_physics dut (
    .frame_clk (frame_clk),
    .Reset     (rst),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int frame;
    int exp_y;
  } fall_vec_t;

  function automatic bit overlap(input int bx, input int by, input int cx, input int cy,
                                 input int s);
    return (bx < cx + s) && (bx + 16 > cx) && (by < cy + s) && (by + 16 > cy);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_step(input bit do_rst);
    int vx, vy, nx, ny;
    m_g1 = 0;
    m_g2 = 0;
    if (do_rst) begin
      m_x = 320; m_y = 200; m_vx = 0; m_vy = 0;
      m_st = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    case (m_st)
      0: begin
        m_x = 320; m_y = 200; m_vx = 0; m_vy = 0;
        if (m_cnt == 29) begin m_cnt = 0; m_st = 1; end
        else m_cnt++;
      end
      2: begin
        if (m_cnt == 59) begin
          m_x = 320; m_y = 200; m_vx = 0; m_vy = 0; m_cnt = 0; m_st = 0;
        end else m_cnt++;
      end
      default: begin
        vx = m_vx;
        vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
        if (overlap(m_x, m_y, c1x, c1y, cs)) begin
          vx = (m_x + 8 >= c1x + cs / 2) ? 6 : -6;
          vy = -10;
        end else if (overlap(m_x, m_y, c2x, c2y, cs)) begin
          vx = (m_x + 8 >= c2x + cs / 2) ? 6 : -6;
          vy = -10;
        end
        nx = m_x + vx;
        ny = m_y + vy;
        if (nx < 0 || nx > 623) begin
          if (m_y >= 320) begin
            if (nx < 0) begin m_g2 = 1; m_s2 = (m_s2 == 15) ? 15 : m_s2 + 1; end
            else begin m_g1 = 1; m_s1 = (m_s1 == 15) ? 15 : m_s1 + 1; end
            m_st = 2;
            m_cnt = 0;
          end else vx = -vx;
          m_x = (nx < 0) ? 0 : 623;
        end else m_x = nx;
        if (ny < 0) begin
          m_y = 0;
          vy = -vy;
        end else if (ny > 384) begin
          m_y = 384;
          vy = -(vy >>> 1);
          if (vy > -2 && vy < 2) vy = 0;
          if (vx > 0) vx--;
          else if (vx < 0) vx++;
        end else m_y = ny;
        m_vx = vx;
        m_vy = vy;
      end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ball_x", int'(bus.BallX), m_x);
    chk("ball_y", int'(bus.BallY), m_y);
    chk("ball_s", int'(bus.BallS), 16);
    chk("state", int'(bus.GameState), m_st);
    chk("goal1", int'(bus.Goal1), m_g1);
    chk("goal2", int'(bus.Goal2), m_g2);
    chk("score1", int'(bus.Score1), m_s1);
    chk("score2", int'(bus.Score2), m_s2);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_step(rst);
    #1;
    check_all();
  endtask

  task automatic chars_away();
    c1x = 0; c1y = 0; c2x = 600; c2y = 0;
  endtask

  task automatic wait_goal(input bit left, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (left ? bus.Goal2 : bus.Goal1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL goal_wait: no goal pulse within %0d frames, required one", bound);
    end
  endtask

  initial begin
    fall_vec_t fall[11];
    int idx;
    int pre_x;
    bit seen;

    fall = '{'{1, 201}, '{2, 203}, '{3, 206}, '{15, 320}, '{16, 335}, '{20, 384},
             '{21, 378}, '{27, 363}, '{33, 384}, '{37, 381}, '{40, 384}};

    // Reset and serve hold.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_x", int'(bus.BallX), 320);
    chk("rst_y", int'(bus.BallY), 200);
    chk("rst_state", int'(bus.GameState), 0);
    chk("rst_scores", int'(bus.Score1) + int'(bus.Score2), 0);
    repeat (29) tick();
    chk("serve_hold", int'(bus.GameState), 0);
    tick();
    chk("serve_to_play", int'(bus.GameState), 1);

    // Free fall with saturating gravity and floor bounces.
    idx = 0;
    for (int f = 1; f <= 60; f++) begin
      tick();
      if (idx < 11 && fall[idx].frame == f) begin
        chk($sformatf("fall_y_f%0d", f), int'(bus.BallY), fall[idx].exp_y);
        idx++;
      end
    end

    // Kick from rest at (320,384).
    c1x = 300; c1y = 368;
    tick();
    chk("kick_x", int'(bus.BallX), 326);
    chk("kick_y", int'(bus.BallY), 374);
    chars_away();
    repeat (60) tick();

    // Both players overlap: player 1 is on the left so the ball must go right.
    pre_x = m_x;
    c1x = pre_x - 20; c1y = 368;
    c2x = pre_x + 10; c2y = 368;
    tick();
    chk("simul_x", int'(bus.BallX), pre_x + 6);
    chars_away();

    // Rightward flight ends in the right goal.
    wait_goal(1'b0, 60, seen);
    chk("rgoal_state", int'(bus.GameState), 2);
    chk("rgoal_x", int'(bus.BallX), 623);
    chk("rgoal_score1", int'(bus.Score1), 1);
    chk("rgoal_no_goal2", int'(bus.Goal2), 0);
    tick();
    chk("rgoal_pulse_width", int'(bus.Goal1), 0);
    repeat (58) tick();
    chk("pause_hold", int'(bus.GameState), 2);
    tick();
    chk("pause_to_serve", int'(bus.GameState), 0);
    chk("pause_x", int'(bus.BallX), 320);
    chk("pause_y", int'(bus.BallY), 200);

    // Serve, fall to rest, two leftward kicks for a left goal.
    repeat (90) tick();
    for (int k = 0; k < 2; k++) begin
      pre_x = m_x;
      c1x = pre_x + 10; c1y = 368;
      tick();
      chk($sformatf("kick_left_x%0d", k), int'(bus.BallX), pre_x - 6);
      chars_away();
      if (k == 0) repeat (60) tick();
    end
    wait_goal(1'b1, 60, seen);
    chk("lgoal_state", int'(bus.GameState), 2);
    chk("lgoal_x", int'(bus.BallX), 0);
    chk("lgoal_score2", int'(bus.Score2), 1);
    chk("lgoal_no_goal1", int'(bus.Goal1), 0);
    tick();
    chk("lgoal_pulse_width", int'(bus.Goal2), 0);

    // Reset during the goal pause.
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("goal_rst_state", int'(bus.GameState), 0);
    chk("goal_rst_score1", int'(bus.Score1), 0);
    chk("goal_rst_score2", int'(bus.Score2), 0);
    chk("goal_rst_x", int'(bus.BallX), 320);

    // Randomized play around the ball, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cs = int'($urandom_range(16, 64));
      if ($urandom_range(0, 3) == 0) begin
        chars_away();
      end else begin
        c1x = clampi(m_x + int'($urandom_range(0, 100)) - 60, 0, 600);
        c1y = clampi(m_y + int'($urandom_range(0, 80)) - 50, 0, 400);
        c2x = clampi(m_x + int'($urandom_range(0, 100)) - 40, 0, 600);
        c2y = clampi(m_y + int'($urandom_range(0, 80)) - 50, 0, 400);
      end
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
